// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int unsigned PC_INC = 4;

    // Flush counter width: $clog2(flush_cycles + 1)
    function automatic int unsigned cnt_width(input int unsigned flush_cycles);
        return $clog2(flush_cycles + 1);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_shift_left.sv
// Constant left shift; scales the halfword branch immediate to a byte offset.
module shift_left #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHAMT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = data_i << SHAMT;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC owner and taken-branch redirect sequencer.
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W       = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int unsigned        FLUSH_CYCLES = 2,
    parameter logic [ADDR_W-1:0]  TRAP_VEC     = 64'h100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] imm_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              redirect_busy,
    output logic              trap_out
);

    localparam int unsigned CNT_W = cnt_width(FLUSH_CYCLES);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                flush_if_id_q;
    logic                flush_id_ex_q;
    logic                busy_q;
    logic                trap_q;

    logic [ADDR_W-1:0]   imm_scaled;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   redirect_pc_d;
    logic                misalign_d;

    shift_left #(
        .WIDTH (ADDR_W),
        .SHAMT (1)
    ) u_imm_shift (
        .data_i (imm_data),
        .data_o (imm_scaled)
    );

    assign target = br_pc + imm_scaled;
    assign pc_inc = pc_q + ADDR_W'(PC_INC);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign_d    = target[1];
        redirect_pc_d = misalign_d ? TRAP_VEC : target;
    end
`else
    // TRAP_VEC only matters when the misalignment trap is built in
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;

    always_comb begin
        misalign_d    = 1'b0;
        redirect_pc_d = target;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            pc_q          <= RESET_PC;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
            busy_q        <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            flush_id_ex_q <= 1'b0;
            trap_q        <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (br_valid && br_taken) begin
                        pc_q          <= redirect_pc_d;
                        trap_q        <= misalign_d;
                        flush_if_id_q <= 1'b1;
                        flush_id_ex_q <= 1'b1;
                        busy_q        <= 1'b1;
                        cnt_q         <= CNT_W'(FLUSH_CYCLES - 1);
                        state_q       <= FLUSH;
                    end else if (!stall_in) begin
                        pc_q <= pc_inc;
                    end
                end
                FLUSH: begin
                    // Branch inputs here belong to the squashed path
                    if (!stall_in) begin
                        pc_q <= pc_inc;
                    end
                    if (cnt_q == '0) begin
                        flush_if_id_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= RUN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign pc_out        = pc_q;
    assign flush_if_id   = flush_if_id_q;
    assign flush_id_ex   = flush_id_ex_q;
    assign redirect_busy = busy_q;
    assign trap_out      = trap_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Owns the fetch PC register and sequences taken-branch redirects for the 5-stage RISC-V pipeline.
- Computes the branch target as br_pc + (imm_data << 1) using the existing halfword-scaled immediate convention.
- Loads the target into the PC and drives IF/ID and ID/EX flushes for a programmable number of cycles.
- Arbitrates redirect against load-use stall.

Parameters:
ADDR_W, 64, PC / address width
RESET_PC, 64'h0, PC value after reset
FLUSH_CYCLES, 2, cycles flush_if_id stays asserted after a redirect (1..7)
TRAP_VEC, 64'h100, PC loaded on a misaligned target (used only with the optional feature)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
stall_in  input  1  hazard-unit stall; hold PC when high
br_valid  input  1  EX stage has resolved a branch/jump this cycle
br_taken  input  1  resolved branch is taken (qualified by br_valid)
br_pc  input  ADDR_W  PC of the resolving branch instruction
imm_data  input  ADDR_W  sign-extended branch immediate, unscaled
pc_out  output  ADDR_W  current fetch PC (registered)
flush_if_id  output  1  clear IF/ID register (registered)
flush_id_ex  output  1  clear ID/EX register (registered)
redirect_busy  output  1  high while in FLUSH state
trap_out  output  1  one-cycle misaligned-target pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (reset==0 at an edge):
  - pc_out=RESET_PC; flush_if_id=0, flush_id_ex=0, redirect_busy=0, trap_out=0.
  - State=RUN; flush counter=0.
  - Reset overrides everything, including mid-FLUSH.
- Target arithmetic:
  - target = br_pc + (imm_data << 1), truncated to ADDR_W (mod 2^ADDR_W); no overflow flag.
  - PC increment: pc_out + 4, wraps mod 2^ADDR_W.
- States: RUN, FLUSH.
- RUN, priority order:
  1. br_valid&&br_taken: pc_out<=target next edge; flush_if_id<=1, flush_id_ex<=1; counter<=FLUSH_CYCLES-1; go FLUSH. Redirect beats stall_in; stall is ignored that cycle.
  2. stall_in: pc_out holds; flushes stay 0.
  3. Otherwise: pc_out<=pc_out+4.
  - br_valid with br_taken=0 has no effect beyond the normal increment/hold.
- FLUSH:
  - redirect_busy=1. flush_id_ex is high only on the first FLUSH cycle. flush_if_id is high for FLUSH_CYCLES cycles total.
  - br_valid/br_taken are ignored, because they are wrong-path.
  - pc_out advances +4 unless stall_in, in which case it holds.
  - counter==0: deassert all flushes; go RUN next edge.
  - FLUSH_CYCLES=1: a single FLUSH cycle, then RUN.
- Latency: a redirect is visible on pc_out one edge after the br_valid&&br_taken cycle.
- The first new branch can be accepted on the first RUN cycle after FLUSH.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: if target[1]==1 on an accepted redirect, pc_out<=TRAP_VEC instead of the target. trap_out pulses 1 cycle, coincident with the pc_out update. The FLUSH sequence proceeds as normal.
- Undefined: no check; target is loaded as computed; trap_out is constant 0; the TRAP_VEC parameter is unused.

Decomposition:
- Shared package (branch_ctrl_pkg):
  - state enum RUN/FLUSH
  - PC_INC=4
  - localparam for counter width, $clog2(FLUSH_CYCLES+1)
- Sub-module: the existing shift_left block, instantiated for the imm_data<<1 scaling. The adder and FSM stay local.

Test Plan:
1. Reset → pc_out sequence. Hold reset=0 for 2 cycles, then release → pc_out=0 after release, then 4, 8, 12 on successive edges; all flushes 0.
2. Taken branch. pc_out=0x20, br_pc=0x18, imm_data=0x10, br_valid=br_taken=1 for one cycle → next pc_out=0x38. flush_id_ex high 1 cycle; flush_if_id and redirect_busy high 2 cycles; then pc_out=0x3C, 0x40.
3. Redirect vs stall. stall_in=1 with a taken branch, br_pc=0x40, imm_data=-8 (0xFFFF_FFFF_FFFF_FFF8) → pc_out=0x30; stall ignored that cycle. A stall during FLUSH holds pc_out at 0x30.
4. Wrong-path branch ignored and wrap. br_taken pulse during FLUSH → no PC change. Separately, br_pc=0xFFFF_FFFF_FFFF_FFF0, imm_data=0x10 → pc_out=0x10 (wraps).
5. Reset mid-FLUSH. reset=0 on the 2nd FLUSH cycle → next edge pc_out=RESET_PC, flushes 0, redirect_busy 0.
6. MISALIGN_TRAP_EN. br_pc=0x0, imm_data=0x1 (target 0x2) → pc_out=0x100, trap_out pulses 1 cycle, flush sequence still runs. Without the macro → pc_out=0x2, trap_out stays 0.
